// File: rtl/apb_master_bridge_if.sv
// rtl/apb_master_bridge_if.sv - request-side and APB-side signal bundle for apb_master_bridge
//
// Signals:
//   req_i/addr_i/we_i/wdata_i   core request (requester -> bridge)
//   gnt_o                       request accepted this cycle
//   rvalid_o/rdata_o/err_o      completion pulse with read data and error flag
//   PADDR/PWDATA/PWRITE         APB address phase (bridge -> slave)
//   PSEL/PENABLE                APB phase control
//   PRDATA/PREADY/PSLVERR       APB slave response
// Modports: master = bridge view, slave = environment (requester + APB slave) view.
interface apb_master_bridge_if #(
    parameter int APB_ADDR_WIDTH = 12
);
    logic                      req_i;
    logic [APB_ADDR_WIDTH-1:0] addr_i;
    logic                      we_i;
    logic [31:0]               wdata_i;
    logic                      gnt_o;
    logic                      rvalid_o;
    logic [31:0]               rdata_o;
    logic                      err_o;
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  req_i, addr_i, we_i, wdata_i, PRDATA, PREADY, PSLVERR,
        output gnt_o, rvalid_o, rdata_o, err_o, PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

    modport slave (
        output req_i, addr_i, we_i, wdata_i, PRDATA, PREADY, PSLVERR,
        input  gnt_o, rvalid_o, rdata_o, err_o, PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );
endinterface

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding req/gnt/rvalid to APB initiator
//
// Ports:
//   HCLK     clock
//   HRESETn  asynchronous active-low reset
//   bus      apb_master_bridge_if.master (request side + APB side)
// Parameters:
//   APB_ADDR_WIDTH  address width of addr_i / PADDR
//   TIMEOUT_CYCLES  wait-state limit before abort (only with APB_MASTER_TIMEOUT_EN)
// Optional feature macro: APB_MASTER_TIMEOUT_EN (ACCESS wait-state timeout with error completion).
module apb_master_bridge #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    apb_master_bridge_if.master bus
);
    // Encoding chosen so PSEL = state[0] and PENABLE = state[1] come straight
    // from flops: glitch-free and cleared asynchronously by HRESETn.
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SETUP  = 2'b01;
    localparam logic [1:0] ST_ACCESS = 2'b11;

    logic [1:0]                state;
    logic [1:0]                state_nxt;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic [31:0]               pwdata_q;
    logic                      pwrite_q;
    logic                      rvalid_q;
    logic                      err_q;
    logic [31:0]               rdata_q;
    logic                      complete;
    logic                      grant;
    logic                      abort;

    assign complete = (state == ST_ACCESS) && bus.PREADY;
    assign grant    = bus.req_i && ((state == ST_IDLE) || complete);

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;

    // Every ACCESS is preceded by SETUP, so clearing there resets the count on ACCESS entry.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wait_cnt <= '0;
        end else if (state == ST_SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ST_ACCESS) && !bus.PREADY) begin
            wait_cnt <= wait_cnt + TW'(1);
        end
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive wait cycle.
    assign abort = (state == ST_ACCESS) && !bus.PREADY &&
                   (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.req_i) state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (complete) begin
                    state_nxt = bus.req_i ? ST_SETUP : ST_IDLE;
                end else if (abort) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                paddr_q  <= bus.addr_i;
                pwdata_q <= bus.wdata_i;
                pwrite_q <= bus.we_i;
            end
        end
    end

    // pwrite_q still describes the completing transfer here: a back-to-back
    // grant on the same edge only updates it after this edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= complete || abort;
            if (complete) begin
                err_q   <= bus.PSLVERR;
                rdata_q <= pwrite_q ? 32'h0 : bus.PRDATA;
            end else if (abort) begin
                err_q   <= 1'b1;
                rdata_q <= 32'h0;
            end
        end
    end

    assign bus.gnt_o    = grant;
    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = rdata_q;
    assign bus.err_o    = err_q;
    assign bus.PADDR    = paddr_q;
    assign bus.PWDATA   = pwdata_q;
    assign bus.PWRITE   = pwrite_q;
    assign bus.PSEL     = state[0];
    assign bus.PENABLE  = state[1];
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - self-checking scoreboard bench for apb_master_bridge
module tb_apb_master_bridge;
    localparam int AW     = 12;
    localparam int TB_TMO = 4;

    logic HCLK;
    logic HRESETn;

    apb_master_bridge_if #(.APB_ADDR_WIDTH(AW)) bus ();

    apb_master_bridge #(
        .APB_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TB_TMO)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int checks = 0;
    int passed = 0;
    int rv_count = 0;

    // Slave model: PREADY rises after cfg_waits ACCESS wait cycles.
    int          cfg_waits = 0;
    logic [31:0] cfg_rdata = 32'h0;
    logic        cfg_err   = 1'b0;
    int          acc_cnt;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) acc_cnt <= 0;
        else if (bus.PSEL && bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    always @(*) begin
        bus.PREADY  = bus.PSEL && bus.PENABLE && (acc_cnt >= cfg_waits);
        bus.PRDATA  = cfg_rdata;
        bus.PSLVERR = cfg_err;
    end

    // Scoreboard: expected completions pushed when a request is driven.
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];
    exp_t sb_e;

    always @(negedge HCLK) begin
        if (HRESETn && bus.rvalid_o) begin
            rv_count++;
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected_rvalid got rdata=%h err=%b, no completion expected",
                         bus.rdata_o, bus.err_o);
            end else begin
                sb_e = sb.pop_front();
                if ({bus.rdata_o, bus.err_o} !== {sb_e.rdata, sb_e.err})
                    $display("FAIL sb_completion got rdata=%h err=%b, expected rdata=%h err=%b",
                             bus.rdata_o, bus.err_o, sb_e.rdata, sb_e.err);
                else
                    passed++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_edge;
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_xfer(input logic [AW-1:0] addr, input logic we, input logic [31:0] wdata,
                           input int waits, input logic [31:0] slv_rdata, input logic slv_err,
                           input logic [31:0] exp_rdata, input logic exp_err, input int exp_acc);
        int  n;
        int  acc;
        bit  got;
        bit  done;
        bit  addr_ok;
        cfg_waits = waits;
        cfg_rdata = slv_rdata;
        cfg_err   = slv_err;
        drive_edge;
        bus.req_i = 1'b1; bus.addr_i = addr; bus.we_i = we; bus.wdata_i = wdata;
        sb.push_back('{rdata: exp_rdata, err: exp_err});
        n = 0; got = 0;
        while (!got && n < 20) begin
            @(negedge HCLK);
            if (bus.gnt_o) got = 1;
            else begin drive_edge; n++; end
        end
        checks++;
        if (!got) $display("FAIL xfer_grant no gnt_o within 20 cycles (addr %h)", addr);
        else passed++;
        drive_edge;
        bus.req_i = 1'b0;
        acc = 0; n = 0; done = 0; addr_ok = 1;
        while (!done && n < 200) begin
            @(negedge HCLK);
            if (bus.rvalid_o) done = 1;
            else begin
                if (bus.PENABLE) acc++;
                if (bus.PSEL && (bus.PADDR !== addr || bus.PWRITE !== we)) addr_ok = 0;
                drive_edge; n++;
            end
        end
        checks++;
        if (!done) $display("FAIL xfer_rvalid no rvalid_o within 200 cycles (addr %h)", addr);
        else passed++;
        checks++;
        if (acc !== exp_acc) $display("FAIL xfer_access_cycles got %0d expected %0d", acc, exp_acc);
        else passed++;
        checks++;
        if (!addr_ok) $display("FAIL xfer_addr_stable PADDR/PWRITE changed during transfer, got %h expected %h",
                               bus.PADDR, addr);
        else passed++;
        checks++;
        if (bus.PSEL !== 1'b0) $display("FAIL xfer_idle_at_rvalid PSEL got %b expected 0", bus.PSEL);
        else passed++;
        drive_edge;
        @(negedge HCLK);
        checks++;
        if (bus.rvalid_o !== 1'b0) $display("FAIL xfer_rvalid_pulse rvalid_o got %b expected 0", bus.rvalid_o);
        else passed++;
    endtask

    task automatic test_reset;
        HRESETn = 1'b0;
        bus.req_i = 1'b0; bus.addr_i = '0; bus.we_i = 1'b0; bus.wdata_i = '0;
        repeat (2) @(negedge HCLK);
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rvalid_o, bus.err_o} !== 5'b0 ||
            bus.PADDR !== '0 || bus.PWDATA !== 32'h0 || bus.rdata_o !== 32'h0)
            $display("FAIL reset_outputs got psel=%b pen=%b pwr=%b rv=%b err=%b paddr=%h pwdata=%h rdata=%h expected all 0",
                     bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rvalid_o, bus.err_o, bus.PADDR, bus.PWDATA, bus.rdata_o);
        else passed++;
        bus.req_i = 1'b1;
        #1;
        checks++;
        if (bus.gnt_o !== 1'b1) $display("FAIL reset_gnt_eq gnt_o got %b expected 1", bus.gnt_o);
        else passed++;
        bus.req_i = 1'b0;
        #1;
        checks++;
        if (bus.gnt_o !== 1'b0) $display("FAIL reset_gnt_idle gnt_o got %b expected 0", bus.gnt_o);
        else passed++;
        drive_edge;
        HRESETn = 1'b1;
    endtask

    task automatic test_write_latency;
        logic [3:0] psel_v, pen_v, rv_v;
        cfg_waits = 0; cfg_err = 1'b0; cfg_rdata = 32'hFFFF_FFFF;
        drive_edge;
        bus.req_i = 1'b1; bus.addr_i = 12'h008; bus.we_i = 1'b1; bus.wdata_i = 32'h0000_9000;
        sb.push_back('{rdata: 32'h0, err: 1'b0});
        @(negedge HCLK);
        checks++;
        if (bus.gnt_o !== 1'b1) $display("FAIL wr_gnt gnt_o got %b expected 1", bus.gnt_o);
        else passed++;
        drive_edge;
        bus.req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            psel_v[i] = bus.PSEL; pen_v[i] = bus.PENABLE; rv_v[i] = bus.rvalid_o;
            if (i == 0) begin
                checks++;
                if (bus.PADDR !== 12'h008 || bus.PWRITE !== 1'b1 || bus.PWDATA !== 32'h0000_9000)
                    $display("FAIL wr_setup_bus got paddr=%h pwrite=%b pwdata=%h expected 008/1/00009000",
                             bus.PADDR, bus.PWRITE, bus.PWDATA);
                else passed++;
            end
            drive_edge;
        end
        checks++;
        if (psel_v !== 4'b0011 || pen_v !== 4'b0010 || rv_v !== 4'b0100)
            $display("FAIL wr_timing got psel=%b pen=%b rvalid=%b expected 0011/0010/0100",
                     psel_v, pen_v, rv_v);
        else passed++;
    endtask

    task automatic test_wait_states;
        do_xfer(12'h014, 1'b0, 32'h0, 3, 32'h0000_0003, 1'b0, 32'h0000_0003, 1'b0, 4);
    endtask

    task automatic test_back_to_back;
        logic [4:0] psel_v, pen_v, gnt_v, rv_v;
        logic [AW-1:0] paddr2;
        logic          pwrite2;
        cfg_waits = 0; cfg_err = 1'b0; cfg_rdata = 32'h1234_5678;
        drive_edge;
        bus.req_i = 1'b1; bus.addr_i = 12'h000; bus.we_i = 1'b1; bus.wdata_i = 32'hA5A5_0001;
        sb.push_back('{rdata: 32'h0, err: 1'b0});
        @(negedge HCLK);
        checks++;
        if (bus.gnt_o !== 1'b1) $display("FAIL b2b_first_gnt gnt_o got %b expected 1", bus.gnt_o);
        else passed++;
        drive_edge;
        bus.addr_i = 12'h010; bus.we_i = 1'b0; bus.wdata_i = 32'h0;
        sb.push_back('{rdata: 32'h1234_5678, err: 1'b0});
        paddr2 = '0; pwrite2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge HCLK);
            psel_v[i] = bus.PSEL; pen_v[i] = bus.PENABLE; gnt_v[i] = bus.gnt_o; rv_v[i] = bus.rvalid_o;
            if (i == 2) begin paddr2 = bus.PADDR; pwrite2 = bus.PWRITE; end
            drive_edge;
            if (i == 1) bus.req_i = 1'b0;
        end
        checks++;
        if (psel_v !== 5'b01111 || pen_v !== 5'b01010)
            $display("FAIL b2b_psel_pen got psel=%b pen=%b expected 01111/01010", psel_v, pen_v);
        else passed++;
        checks++;
        if (gnt_v !== 5'b00010) $display("FAIL b2b_gnt got %b expected 00010", gnt_v);
        else passed++;
        checks++;
        if (rv_v !== 5'b10100) $display("FAIL b2b_rvalid got %b expected 10100", rv_v);
        else passed++;
        checks++;
        if (paddr2 !== 12'h010 || pwrite2 !== 1'b0)
            $display("FAIL b2b_second_addr got paddr=%h pwrite=%b expected 010/0", paddr2, pwrite2);
        else passed++;
    endtask

    task automatic test_slave_error;
        do_xfer(12'h020, 1'b0, 32'h0, 1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 2);
        repeat (2) @(negedge HCLK);
        checks++;
        if (bus.err_o !== 1'b1 || bus.rdata_o !== 32'hDEAD_BEEF)
            $display("FAIL err_hold got err=%b rdata=%h expected 1/deadbeef", bus.err_o, bus.rdata_o);
        else passed++;
        do_xfer(12'h024, 1'b1, 32'h0000_0055, 0, 32'hCAFE_0000, 1'b0, 32'h0, 1'b0, 1);
        checks++;
        if (bus.err_o !== 1'b0) $display("FAIL err_cleared got err=%b expected 0", bus.err_o);
        else passed++;
    endtask

    task automatic test_reset_mid_access;
        int rv_before;
        int n;
        bit got;
        cfg_waits = 1000; cfg_err = 1'b0; cfg_rdata = 32'h0;
        drive_edge;
        bus.req_i = 1'b1; bus.addr_i = 12'h030; bus.we_i = 1'b0; bus.wdata_i = 32'h0;
        n = 0; got = 0;
        while (!got && n < 20) begin
            @(negedge HCLK);
            if (bus.gnt_o) got = 1;
            else begin drive_edge; n++; end
        end
        drive_edge;
        bus.req_i = 1'b0;
        repeat (3) @(negedge HCLK);
        checks++;
        if (!got || bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b1)
            $display("FAIL rst_mid_in_access got gnt_seen=%b psel=%b pen=%b expected 1/1/1",
                     got, bus.PSEL, bus.PENABLE);
        else passed++;
        rv_before = rv_count;
        HRESETn = 1'b0;
        #1;
        checks++;
        if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0 || bus.rvalid_o !== 1'b0)
            $display("FAIL rst_mid_async got psel=%b pen=%b rvalid=%b expected 0/0/0",
                     bus.PSEL, bus.PENABLE, bus.rvalid_o);
        else passed++;
        sb.delete();
        cfg_waits = 0;
        repeat (2) @(negedge HCLK);
        drive_edge;
        HRESETn = 1'b1;
        repeat (3) @(negedge HCLK);
        checks++;
        if (rv_count !== rv_before || bus.PSEL !== 1'b0)
            $display("FAIL rst_mid_no_rvalid got pulses=%0d psel=%b expected %0d/0",
                     rv_count, bus.PSEL, rv_before);
        else passed++;
        do_xfer(12'h034, 1'b0, 32'h0, 0, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 1);
    endtask

`ifdef APB_MASTER_TIMEOUT_EN
    task automatic test_timeout;
        do_xfer(12'h040, 1'b0, 32'h0, 1000, 32'h0000_ABCD, 1'b0, 32'h0, 1'b1, TB_TMO);
        cfg_waits = 0;
        do_xfer(12'h044, 1'b0, 32'h0, 0, 32'h0000_0777, 1'b0, 32'h0000_0777, 1'b0, 1);
    endtask
`endif

    initial begin
        test_reset;
        test_write_latency;
        test_wait_states;
        test_back_to_back;
        test_slave_error;
        test_reset_mid_access;
`ifdef APB_MASTER_TIMEOUT_EN
        test_timeout;
`endif
        repeat (3) @(negedge HCLK);
        checks++;
        if (sb.size() != 0) $display("FAIL sb_drained %0d completions outstanding, expected 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
